cpu_fetch: RTL and testbench

CPU_FETCH -- requirements
Module: cpu_fetch

---
 rtl/cpu_fetch.sv | 166 ++++++++++++++++
 tb/tb_cpu_fetch.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_fetch.sv
// Instruction fetch front end: in-order request stream, prefetch FIFO and kill/redirect handling.
// Optional macro CPU_FETCH_BYPASS_EN presents a response in its arrival cycle when the FIFO is empty.
module cpu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_b,
  output logic        imem__req,
  output logic [30:0] imem__addr,
  input  logic        imem__gnt,
  input  logic        imem__rvalid,
  input  logic [47:0] imem__rdata,
  output logic [47:0] instruction_1a,
  output logic [31:0] pc_1a,
  input  logic        stall_2a,
  input  logic        kill_4a,
  input  logic [31:0] pc_4a
);

  logic        run_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] rsp_pc_q, rsp_pc_d;
  logic [31:0] last_pc_q, last_pc_d;
  logic [2:0]  out_q, out_d;
  logic [7:0]  drop_q, drop_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  wr_q, wr_d;
  logic [1:0]  rd_q, rd_d;
  logic [47:0] fifo_data_q [4];
  logic [31:0] fifo_pc_q   [4];

  logic head_valid_s, live_rsp_s, byp_s, pop_s, push_s, acc_s;

  function automatic logic [31:0] pc_next(input logic [31:0] p);
    pc_next = {p[31:1] + 31'd1, p[0]};
  endfunction

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    if (p == 2'(DEPTH - 1)) begin
      ptr_next = 2'd0;
    end else begin
      ptr_next = p + 2'd1;
    end
  endfunction

  // Pending drops are always older than live requests, so a response is live only once drops are exhausted.
  assign live_rsp_s   = imem__rvalid && (drop_q == 8'd0);
  assign head_valid_s = (cnt_q != 3'd0);
`ifdef CPU_FETCH_BYPASS_EN
  assign byp_s = !head_valid_s && live_rsp_s && !kill_4a;
`else
  assign byp_s = 1'b0;
`endif
  assign pop_s      = head_valid_s && !stall_2a && !kill_4a;
  assign push_s     = live_rsp_s && !kill_4a && !(byp_s && !stall_2a);
  assign imem__req  = run_q && !kill_4a && (({1'b0, out_q} + {1'b0, cnt_q}) < 4'(DEPTH));
  assign imem__addr = pc_q[31:1];
  assign acc_s      = imem__req && imem__gnt;

  // Decode-side view: FIFO head, else bypassed response, else NOP with the last presented pc.
  always_comb begin
    instruction_1a = 48'h0;
    pc_1a          = last_pc_q;
    if (head_valid_s) begin
      instruction_1a = fifo_data_q[rd_q];
      pc_1a          = fifo_pc_q[rd_q];
    end else if (byp_s) begin
      instruction_1a = imem__rdata;
      pc_1a          = rsp_pc_q;
    end else begin
      instruction_1a = 48'h0;
      pc_1a          = last_pc_q;
    end
  end

  // Next-state for fetch pointer, in-flight accounting and FIFO pointers; kill overrides everything.
  always_comb begin
    pc_d      = pc_q;
    rsp_pc_d  = rsp_pc_q;
    last_pc_d = last_pc_q;
    out_d     = out_q;
    drop_d    = drop_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    if (head_valid_s) begin
      last_pc_d = fifo_pc_q[rd_q];
    end else if (byp_s) begin
      last_pc_d = rsp_pc_q;
    end else begin
      last_pc_d = last_pc_q;
    end
    if (kill_4a) begin
      pc_d     = pc_4a;
      rsp_pc_d = pc_4a;
      out_d    = 3'd0;
      drop_d   = drop_q + {5'd0, out_q} - {7'd0, imem__rvalid};
      cnt_d    = 3'd0;
      wr_d     = 2'd0;
      rd_d     = 2'd0;
    end else begin
      if (acc_s) begin
        pc_d = pc_next(pc_q);
      end else begin
        pc_d = pc_q;
      end
      if (live_rsp_s) begin
        rsp_pc_d = pc_next(rsp_pc_q);
      end else begin
        rsp_pc_d = rsp_pc_q;
      end
      out_d = out_q + {2'd0, acc_s} - {2'd0, live_rsp_s};
      if (imem__rvalid && !live_rsp_s) begin
        drop_d = drop_q - 8'd1;
      end else begin
        drop_d = drop_q;
      end
      cnt_d = cnt_q + {2'd0, push_s} - {2'd0, pop_s};
      if (push_s) begin
        wr_d = ptr_next(wr_q);
      end else begin
        wr_d = wr_q;
      end
      if (pop_s) begin
        rd_d = ptr_next(rd_q);
      end else begin
        rd_d = rd_q;
      end
    end
  end

  // State registers and FIFO storage.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      run_q     <= 1'b0;
      pc_q      <= RESET_PC;
      rsp_pc_q  <= RESET_PC;
      last_pc_q <= RESET_PC;
      out_q     <= 3'd0;
      drop_q    <= 8'd0;
      cnt_q     <= 3'd0;
      wr_q      <= 2'd0;
      rd_q      <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        fifo_data_q[i] <= 48'h0;
        fifo_pc_q[i]   <= 32'h0;
      end
    end else begin
      run_q     <= 1'b1;
      pc_q      <= pc_d;
      rsp_pc_q  <= rsp_pc_d;
      last_pc_q <= last_pc_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      if (push_s) begin
        fifo_data_q[wr_q] <= imem__rdata;
        fifo_pc_q[wr_q]   <= rsp_pc_q;
      end
    end
  end

endmodule

// File: tb/tb_cpu_fetch.sv
// Scoreboard bench for cpu_fetch: an in-order memory model with variable latency, directed
// reset/stall/kill scenarios, and a monitor that checks every consumed instruction.
module tb_cpu_fetch;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        imem__req;
  logic [30:0] imem__addr;
  logic        imem__gnt;
  logic        imem__rvalid;
  logic [47:0] imem__rdata;
  logic [47:0] instruction_1a;
  logic [31:0] pc_1a;
  logic        stall_2a;
  logic        kill_4a;
  logic [31:0] pc_4a;

  typedef struct { logic [30:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [47:0] data; } exp_t;

  pend_t       pend_q[$];
  exp_t        exp_q[$];
  logic [30:0] glog_addr[$];
  int          glog_cyc[$];
  int          cons_cyc[$];
  int          lat = 1;
  int          cycle = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_seen;

  cpu_fetch #(.RESET_PC(32'h100), .DEPTH(2)) dut (
    .clk(clk), .rst_b(rst_b),
    .imem__req(imem__req), .imem__addr(imem__addr), .imem__gnt(imem__gnt),
    .imem__rvalid(imem__rvalid), .imem__rdata(imem__rdata),
    .instruction_1a(instruction_1a), .pc_1a(pc_1a),
    .stall_2a(stall_2a), .kill_4a(kill_4a), .pc_4a(pc_4a)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] mkdata(input logic [30:0] a);
    return {17'h15A5A, a};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] start, input int n);
    logic [31:0] p;
    p = start;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back('{p, mkdata(p[31:1])});
      p = {p[31:1] + 31'd1, p[0]};
    end
  endtask

  task automatic do_reset(input logic st);
    tick();
    rst_b    = 1'b0;
    stall_2a = st;
    kill_4a  = 1'b0;
    repeat (2) tick();
    exp_q.delete();
    glog_addr.delete();
    glog_cyc.delete();
    cons_cyc.delete();
    rst_b = 1'b1;
  endtask

  task automatic wait_grants(input int n, input string nm);
    int i;
    i = 0;
    while (glog_addr.size() < n && i < 40) begin
      tick();
      i++;
    end
    if (glog_addr.size() < n) chk({nm, "_grant_timeout"}, 64'(glog_addr.size()), 64'(n));
  endtask

  task automatic wait_head(input logic [31:0] pc, input string nm);
    int i;
    logic seen;
    i = 0;
    seen = 1'b0;
    while (!seen && i < 40) begin
      @(negedge clk);
      if (instruction_1a != 48'h0 && pc_1a == pc) seen = 1'b1;
      i++;
    end
    chk({nm, "_target_seen"}, 64'(seen), 64'd1);
    tick();
  endtask

  // In-order memory: responses driven just after posedge, grants sampled at negedge.
  initial begin
    imem__rvalid = 1'b0;
    imem__rdata  = 48'h0;
    imem__gnt    = 1'b1;
    forever begin
      @(posedge clk);
      cycle++;
      #1;
      if (!rst_b) begin
        pend_q.delete();
        imem__rvalid = 1'b0;
        imem__rdata  = 48'h0;
      end else if (pend_q.size() > 0 && pend_q[0].due <= cycle) begin
        imem__rvalid = 1'b1;
        imem__rdata  = mkdata(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else begin
        imem__rvalid = 1'b0;
        imem__rdata  = 48'h0;
      end
      @(negedge clk);
      if (rst_b && imem__req && imem__gnt) begin
        pend_q.push_back('{imem__addr, cycle + lat});
        glog_addr.push_back(imem__addr);
        glog_cyc.push_back(cycle);
      end
    end
  end

  // Monitor: pops the scoreboard on every consumed head, checks pc hold when no instruction is shown.
  always @(negedge clk) begin
    if (!rst_b) begin
      last_seen = 32'h100;
    end else if (instruction_1a != 48'h0) begin
      last_seen = pc_1a;
      if (!stall_2a && !kill_4a) begin
        cons_cyc.push_back(cycle);
        if (exp_q.size() == 0) begin
          chk("unexpected_instr_pc", 64'(pc_1a), 64'hFFFF_FFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("head_pc", 64'(pc_1a), 64'(e.pc));
          chk("head_instr", 64'(instruction_1a), 64'(e.data));
        end
      end
    end else begin
      chk("empty_pc_hold", 64'(pc_1a), 64'(last_seen));
    end
  end

  initial begin
    int n;
    int gs;
    rst_b    = 1'b0;
    stall_2a = 1'b0;
    kill_4a  = 1'b0;
    pc_4a    = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req", 64'(imem__req), 64'd0);
    chk("rst_instr", 64'(instruction_1a), 64'd0);
    chk("rst_pc", 64'(pc_1a), 64'h100);

    // Free-running fetch after reset, latency 1
    lat = 1;
    do_reset(1'b0);
    push_exp(32'h100, 30);
    wait_grants(1, "t1");
    n = 0;
    while (cons_cyc.size() == 0 && n < 20) begin
      tick();
      n++;
    end
    if (glog_addr.size() > 0) chk("t1_first_addr", 64'(glog_addr[0]), 64'h80);
    if (cons_cyc.size() > 0 && glog_cyc.size() > 0) begin
`ifdef CPU_FETCH_BYPASS_EN
      chk("t1_first_latency", 64'(cons_cyc[0] - glog_cyc[0]), 64'd1);
`else
      chk("t1_first_latency", 64'(cons_cyc[0] - glog_cyc[0]), 64'd2);
`endif
    end else begin
      chk("t1_first_instr_timeout", 64'(cons_cyc.size()), 64'd1);
    end
    repeat (10) tick();
    if (glog_addr.size() >= 3) begin
      chk("t1_addr1", 64'(glog_addr[1]), 64'h81);
      chk("t1_addr2", 64'(glog_addr[2]), 64'h82);
    end else begin
      chk("t1_grant_count", 64'(glog_addr.size()), 64'd3);
    end

    // Decode stalled from reset: capacity cap, then consecutive release
    do_reset(1'b1);
    push_exp(32'h100, 30);
    repeat (12) tick();
    chk("t2_grants_while_stalled", 64'(glog_addr.size()), 64'd2);
    chk("t2_req_when_full", 64'(imem__req), 64'd0);
    chk("t2_head_pc", 64'(pc_1a), 64'h100);
    chk("t2_head_instr", 64'(instruction_1a), 64'(mkdata(31'h80)));
    stall_2a = 1'b0;
    repeat (4) tick();
    if (cons_cyc.size() >= 2) chk("t2_release_gap", 64'(cons_cyc[1] - cons_cyc[0]), 64'd1);
    else chk("t2_release_count", 64'(cons_cyc.size()), 64'd2);

    // Kill with two fetches outstanding, latency 3
    lat = 3;
    do_reset(1'b0);
    wait_grants(2, "t3");
    n = cycle;
    kill_4a = 1'b1;
    pc_4a   = 32'h401;
    exp_q.delete();
    push_exp(32'h401, 30);
    tick();
    kill_4a = 1'b0;
    wait_grants(3, "t3b");
    if (glog_addr.size() >= 3) begin
      chk("t3_redirect_addr", 64'(glog_addr[2]), 64'h200);
      chk("t3_redirect_cycle", 64'(glog_cyc[2]), 64'(n + 1));
    end
    wait_head(32'h401, "t3");

    // Back-to-back kills with responses in flight
    repeat (3) tick();
    kill_4a = 1'b1;
    pc_4a   = 32'h600;
    exp_q.delete();
    tick();
    pc_4a = 32'h800;
    exp_q.delete();
    push_exp(32'h800, 30);
    gs = glog_addr.size();
    tick();
    kill_4a = 1'b0;
    wait_grants(gs + 1, "t4");
    if (glog_addr.size() > gs) chk("t4_redirect_addr", 64'(glog_addr[gs]), 64'h400);
    wait_head(32'h800, "t4");

    // Response arriving in the kill cycle with an empty FIFO is dropped
    lat = 1;
    do_reset(1'b0);
    wait_grants(1, "t5");
    kill_4a = 1'b1;
    pc_4a   = 32'hA00;
    exp_q.delete();
    push_exp(32'hA00, 30);
    @(negedge clk);
    chk("t5_rvalid_flag", 64'(imem__rvalid), 64'd1);
    chk("t5_instr_kill_cycle", 64'(instruction_1a), 64'd0);
    tick();
    kill_4a = 1'b0;
    @(negedge clk);
    chk("t5_instr_after_kill", 64'(instruction_1a), 64'd0);
    wait_head(32'hA00, "t5");

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
